// File: rtl/heston_pkg.sv
// Shared definitions for the Heston payoff accumulator.
//   state_t      : controller FSM states
//   FRAC_W, Q_W  : unsigned Q16.16 price format
//   FP_*         : IEEE-754 binary32 field widths and exponent bias
//   EXP_MIN/MAX  : biased exponent window that maps to a representable,
//                  non-zero, non-clamped Q16.16 value
package heston_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam int FRAC_W    = 16;
  localparam int Q_W       = 32;
  localparam int FP_EXP_W  = 8;
  localparam int FP_MANT_W = 23;
  localparam int EXP_BIAS  = 127;

  // 2^(e-127) * 2^16 >= 1 LSB  <=>  e >= 111
  localparam int EXP_MIN = EXP_BIAS - FRAC_W;
  // value >= 2^16 no longer fits the integer part
  localparam int EXP_MAX = EXP_BIAS + (Q_W - FRAC_W);

endpackage

// File: rtl/heston_payoff_accum_if.sv
// Host-side bundle of the payoff accumulator.
//   start, price1, price2, strike, num_paths : host -> accumulator
//   payoff_sum, paths_done, busy, done, sat   : accumulator -> host
// master = host / core side, slave = accumulator.
interface heston_payoff_accum_if #(
  parameter int ACC_W = 48
);
  logic             start;
  logic [31:0]      price1;
  logic [31:0]      price2;
  logic [31:0]      strike;
  logic [15:0]      num_paths;
  logic [ACC_W-1:0] payoff_sum;
  logic [15:0]      paths_done;
  logic             busy;
  logic             done;
  logic             sat;

  modport master (
    output start, price1, price2, strike, num_paths,
    input  payoff_sum, paths_done, busy, done, sat
  );

  modport slave (
    input  start, price1, price2, strike, num_paths,
    output payoff_sum, paths_done, busy, done, sat
  );
endinterface

// File: rtl/fp32_to_ufix16q16.sv
// Combinational fp32 -> unsigned Q16.16 converter.
//   fp  : IEEE-754 binary32 input
//   q   : Q16.16 result, truncated toward zero
//   sat : NaN input, or positive value >= 2^16 / +Inf (q clamped to all ones)
// Negative values, zeros, denormals and values below one LSB give 0.
module fp32_to_ufix16q16
  import heston_pkg::*;
(
  input  logic [31:0]    fp,
  output logic [Q_W-1:0] q,
  output logic           sat
);

  logic                 sign;
  logic [FP_EXP_W-1:0]  exp_f;
  logic [FP_MANT_W-1:0] mant;
  logic [4:0]           sh;

  assign {sign, exp_f, mant} = fp;

  // Only meaningful inside [EXP_MIN, EXP_MAX): shift range 0..31.
  assign sh = 5'(exp_f - FP_EXP_W'(EXP_MIN));

  always_comb begin
    q   = '0;
    sat = 1'b0;
    if (exp_f == '1 && mant != '0) begin
      sat = 1'b1;
    end else if (sign) begin
      q = '0;
    end else if (exp_f >= FP_EXP_W'(EXP_MAX)) begin
      q   = '1;
      sat = 1'b1;
    end else if (exp_f < FP_EXP_W'(EXP_MIN)) begin
      q = '0;
    end else begin
      // {1.mant} * 2^(e-111) / 2^23, dropping the fraction below 2^-16
      q = Q_W'(({{Q_W{1'b0}}, 1'b1, mant} << sh) >> FP_MANT_W);
    end
  end

endmodule

// File: rtl/heston_payoff_accum.sv
// European call payoff accumulator for the two-lane Heston core.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of heston_payoff_accum_if
//                start/strike/num_paths sampled on accepted start,
//                price1/price2 sampled at each path end,
//                payoff_sum (Q32.16), paths_done, busy, done, sat reported.
// The path-end schedule is free-running from start: LEAD_CYC lead cycles,
// then one sample every CYC_PER_STEP*(STEPS+1) cycles.
//
// state | meaning
// IDLE  | waiting for first start
// LEAD  | core warm-up before path 1
// RUN   | path cycles; sample prices at last cycle of each path
// DRAIN | waiting for the conversion stage to empty
// DONE  | result held until next start
module heston_payoff_accum
  import heston_pkg::*;
#(
  parameter int CYC_PER_STEP = 4,
  parameter int STEPS        = 365,
  parameter int LEAD_CYC     = 6,
  parameter int ACC_W        = 48
) (
  input  logic clk,
  input  logic rst_n,
  heston_payoff_accum_if.slave bus
);

  localparam int CYC_PER_PATH = CYC_PER_STEP * (STEPS + 1);
  localparam int CYC_W        = $clog2(CYC_PER_PATH + 1);
  localparam int LEAD_W       = $clog2(LEAD_CYC + 1);
  localparam int SUM_W        = ACC_W + 1;

  state_t state, state_nxt;

  logic [LEAD_W-1:0] lead_cnt;
  logic [CYC_W-1:0]  cyc_cnt;
  logic [15:0]       paths_issued;
  logic [15:0]       num_lat;
  logic [31:0]       strike_lat;

  logic              s1_vld;
  logic [Q_W-1:0]    s1_x1, s1_x2;

  logic [ACC_W-1:0]  sum_q;
  logic [15:0]       paths_done_q;
  logic              sat_q;

  logic              start_ok, lead_end, path_end, sample, last_path;
  logic [Q_W-1:0]    c1_q, c2_q;
  logic              c1_sat, c2_sat;
  logic [Q_W-1:0]    pay1, pay2;
  logic [SUM_W-1:0]  sum_wide;

  assign start_ok  = bus.start && (state == ST_IDLE || state == ST_DONE);
  assign lead_end  = (lead_cnt == LEAD_W'(LEAD_CYC - 1));
  assign path_end  = (cyc_cnt == CYC_W'(CYC_PER_PATH - 1));
  assign sample    = (state == ST_RUN) && path_end;
  assign last_path = sample && ((paths_issued + 16'd1) == num_lat);

  fp32_to_ufix16q16 u_conv1 (.fp(bus.price1), .q(c1_q), .sat(c1_sat));
  fp32_to_ufix16q16 u_conv2 (.fp(bus.price2), .q(c2_q), .sat(c2_sat));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: if (start_ok) state_nxt = (bus.num_paths == '0) ? ST_DRAIN : ST_LEAD;
      ST_LEAD:          if (lead_end) state_nxt = ST_RUN;
      ST_RUN:           if (last_path) state_nxt = ST_DRAIN;
      ST_DRAIN:         if (!s1_vld) state_nxt = ST_DONE;
      default:          state_nxt = ST_IDLE;
    endcase
  end

  // Schedule counters and job parameters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lead_cnt     <= '0;
      cyc_cnt      <= '0;
      paths_issued <= '0;
      num_lat      <= '0;
      strike_lat   <= '0;
    end else if (start_ok) begin
      lead_cnt     <= '0;
      cyc_cnt      <= '0;
      paths_issued <= '0;
      num_lat      <= bus.num_paths;
      strike_lat   <= bus.strike;
    end else begin
      if (state == ST_LEAD) begin
        lead_cnt <= lead_end ? '0 : lead_cnt + 1'b1;
        cyc_cnt  <= '0;
      end
      if (state == ST_RUN) begin
        cyc_cnt <= path_end ? '0 : cyc_cnt + 1'b1;
        if (sample) paths_issued <= paths_issued + 16'd1;
      end
    end
  end

  // S1: converted prices
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s1_x1  <= '0;
      s1_x2  <= '0;
    end else begin
      s1_vld <= sample;
      if (sample) begin
        s1_x1 <= c1_q;
        s1_x2 <= c2_q;
      end
    end
  end

  // S2: payoff per lane and saturating accumulate
  assign pay1     = (s1_x1 > strike_lat) ? s1_x1 - strike_lat : '0;
  assign pay2     = (s1_x2 > strike_lat) ? s1_x2 - strike_lat : '0;
  assign sum_wide = {1'b0, sum_q} + SUM_W'(pay1) + SUM_W'(pay2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q        <= '0;
      paths_done_q <= '0;
      sat_q        <= 1'b0;
    end else if (start_ok) begin
      sum_q        <= '0;
      paths_done_q <= '0;
      sat_q        <= 1'b0;
    end else begin
      if (sample && (c1_sat || c2_sat)) sat_q <= 1'b1;
      if (s1_vld) begin
        paths_done_q <= paths_done_q + 16'd1;
        if (sum_wide[ACC_W]) begin
          sum_q <= '1;
          sat_q <= 1'b1;
        end else begin
          sum_q <= sum_wide[ACC_W-1:0];
        end
      end
    end
  end

  assign bus.payoff_sum = sum_q;
  assign bus.paths_done = paths_done_q;
  assign bus.sat        = sat_q;
  assign bus.done       = (state == ST_DONE);
  assign bus.busy       = (state == ST_LEAD) || (state == ST_RUN) || (state == ST_DRAIN);

endmodule

// File: tb/tb_heston_payoff_accum.sv
module tb_heston_payoff_accum;

  localparam int CYC_PER_STEP = 2;
  localparam int STEPS        = 3;
  localparam int LEAD_CYC     = 6;
  localparam int ACC_W        = 48;
  localparam int CPP          = CYC_PER_STEP * (STEPS + 1);

  typedef struct {
    string       name;
    logic [31:0] k;
    logic [15:0] n;
    logic [31:0] p1;
    logic [31:0] p2;
    logic [47:0] inc;     // expected payoff added per path (both lanes)
    logic        sat;
    int          inject;  // loop cycle at which a stray start is pulsed, -1 none
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  heston_payoff_accum_if #(.ACC_W(ACC_W)) bus ();

  heston_payoff_accum #(
    .CYC_PER_STEP(CYC_PER_STEP),
    .STEPS       (STEPS),
    .LEAD_CYC    (LEAD_CYC),
    .ACC_W       (ACC_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [ACC_W-1:0] exp_q[$];
  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Real prices only in the cycle before a path-end edge; noise elsewhere.
  task automatic drive_prices(input vec_t v, input int edge_no);
    if (edge_no > LEAD_CYC && ((edge_no - LEAD_CYC) % CPP) == 0) begin
      bus.price1 = v.p1;
      bus.price2 = v.p2;
    end else begin
      bus.price1 = $urandom;
      bus.price2 = $urandom;
    end
  endtask

  task automatic run_job(input vec_t v, input int abort_at);
    int cnt;
    int exp_lat;
    logic [15:0] last_pd;
    logic [ACC_W-1:0] e;
    bus.strike    = v.k;
    bus.num_paths = v.n;
    drive_prices(v, 0);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk({v.name, "_start_busy"}, 64'(bus.busy), 64'd1);
    chk({v.name, "_start_done"}, 64'(bus.done), 64'd0);
    chk({v.name, "_start_sum"},  64'(bus.payoff_sum), 64'd0);
    chk({v.name, "_start_pd"},   64'(bus.paths_done), 64'd0);
    exp_q.delete();
    for (int k = 1; k <= int'(v.n); k++) exp_q.push_back(ACC_W'(k) * v.inc);
    exp_lat = (v.n == 0) ? 1 : LEAD_CYC + int'(v.n) * CPP + 2;
    cnt = 0;
    last_pd = '0;
    while (!bus.done && cnt < 400) begin
      drive_prices(v, cnt + 1);
      bus.start = (cnt == v.inject);
      @(negedge clk);
      cnt++;
      if (cnt == abort_at) begin
        bus.start = 1'b0;
        chk("abort_pre_sum", 64'(bus.payoff_sum), 64'h140000);
        rst_n = 1'b0;
        #1;
        chk("abort_sum",  64'(bus.payoff_sum), 64'd0);
        chk("abort_pd",   64'(bus.paths_done), 64'd0);
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_done", 64'(bus.done), 64'd0);
        chk("abort_sat",  64'(bus.sat), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        return;
      end
      if (bus.paths_done != last_pd) begin
        last_pd = bus.paths_done;
        if (exp_q.size() == 0) begin
          chk({v.name, "_sb_extra_path"}, 64'(bus.paths_done), 64'(v.n));
        end else begin
          e = exp_q.pop_front();
          chk({v.name, "_sb_sum"}, 64'(bus.payoff_sum), 64'(e));
        end
      end
    end
    bus.start = 1'b0;
    chk({v.name, "_done"},    64'(bus.done), 64'd1);
    chk({v.name, "_latency"}, 64'(cnt), 64'(exp_lat));
    chk({v.name, "_sum"},     64'(bus.payoff_sum), 64'(ACC_W'(v.n) * v.inc));
    chk({v.name, "_paths"},   64'(bus.paths_done), 64'(v.n));
    chk({v.name, "_sat"},     64'(bus.sat), 64'(v.sat));
    chk({v.name, "_busy"},    64'(bus.busy), 64'd0);
    chk({v.name, "_sb_left"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    //          name        K             n      price1        price2        per-path      sat  inject
    vecs[0] = '{"basic",    32'h005A0000, 16'd3, 32'h42C80000, 32'h42C80000, 48'h140000,   1'b0, -1};
    vecs[1] = '{"otm",      32'h005A0000, 16'd2, 32'h42A00000, 32'h42C80000, 48'h0A0000,   1'b0, -1};
    vecs[2] = '{"clamp",    32'h00000000, 16'd2, 32'hC2C80000, 32'h47800000, 48'hFFFFFFFF, 1'b1, -1};
    vecs[3] = '{"zero_n",   32'h005A0000, 16'd0, 32'h42C80000, 32'h42C80000, 48'h0,        1'b0, -1};
    vecs[4] = '{"ign_start",32'h005A0000, 16'd3, 32'h42C80000, 32'h42C80000, 48'h140000,   1'b0, 17};
    vecs[5] = '{"nan",      32'h00000000, 16'd1, 32'h7FC00000, 32'h3F800000, 48'h10000,    1'b1, -1};
    vecs[6] = '{"trunc",    32'h00000000, 16'd3, 32'h3EAAAAAB, 32'h37800000, 48'h5556,     1'b0, -1};
    vecs[7] = '{"at_k",     32'h00640000, 16'd2, 32'h42C80000, 32'h42CA0000, 48'h10000,    1'b0, -1};
    vecs[8] = '{"max_fit",  32'h00000000, 16'd1, 32'h477FFF80, 32'h00000000, 48'hFFFF8000, 1'b0, -1};

    bus.start = 1'b0;
    bus.price1 = '0;
    bus.price2 = '0;
    bus.strike = '0;
    bus.num_paths = '0;
    repeat (2) @(negedge clk);
    chk("rst_sum",  64'(bus.payoff_sum), 64'd0);
    chk("rst_pd",   64'(bus.paths_done), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_sat",  64'(bus.sat), 64'd0);
    rst_n = 1'b1;

    // back-to-back jobs: each start after the first is accepted in DONE
    for (int i = 0; i < 9; i++) run_job(vecs[i], -1);

    // reset during path 2 of a basic job, then the same job again
    run_job(vecs[0], 17);
    run_job(vecs[0], -1);

    // stray start while sitting in DONE restarts cleanly
    run_job(vecs[1], -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
